// File: rtl/alarm_trigger_module.sv
// ============================================================================
//  Module   : alarm_trigger_module
//  Purpose  : Compares the alarm word for the current weekday against the
//             running time of day. On a fresh match it rings the buzzer and
//             runs a ring / snooze / stop state machine.
//  Ports    :
//    Clk            in   system clock, rising edge
//    Clr            in   asynchronous active-low reset
//    Q_r0..Q_r6     in   13-bit alarm words, Sunday..Saturday
//                        [12:8] hour, [7:2] minute, [1] reserved, [0] enable
//    day            in   weekday 0..6, 7 = invalid (never matches)
//    hour, minute   in   current time of day
//    sec_tick       in   one-cycle pulse per second
//    snooze, stop   in   one-cycle user requests
//    buzzer         out  buzzer drive, toggles per second while ringing
//    ringing        out  high while ringing
//    snoozing       out  high while snoozing
//    snooze_cnt     out  snoozes used in the current alarm event
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_trigger_module #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [12:0] Q_r0,
  input  logic [12:0] Q_r1,
  input  logic [12:0] Q_r2,
  input  logic [12:0] Q_r3,
  input  logic [12:0] Q_r4,
  input  logic [12:0] Q_r5,
  input  logic [12:0] Q_r6,
  input  logic [2:0]  day,
  input  logic [4:0]  hour,
  input  logic [5:0]  minute,
  input  logic        sec_tick,
  input  logic        snooze,
  input  logic        stop,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozing,
  output logic [1:0]  snooze_cnt
);

  localparam logic [15:0] RING_TICKS   = 16'(RING_SECONDS);
  localparam logic [15:0] SNOOZE_TICKS = 16'(SNOOZE_MINUTES * 60);
  localparam logic [1:0]  MAX_SN       = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic        buzzer_q, buzzer_d;
  logic        match_q;

  logic [12:0] word_sel;
  logic        day_valid;
  logic        match;
  logic        trig;

  // Weekday select; day 7 yields no valid word.
  always_comb begin
    word_sel  = 13'd0;
    day_valid = 1'b1;
    case (day)
      3'd0:    word_sel = Q_r0;
      3'd1:    word_sel = Q_r1;
      3'd2:    word_sel = Q_r2;
      3'd3:    word_sel = Q_r3;
      3'd4:    word_sel = Q_r4;
      3'd5:    word_sel = Q_r5;
      3'd6:    word_sel = Q_r6;
      default: day_valid = 1'b0;
    endcase
  end

  assign match = day_valid & word_sel[0] &
                 (word_sel[12:8] == hour) & (word_sel[7:2] == minute);

  // Rising edge only, so a matching minute fires once. match_q resets to 1
  // so a time already matching at reset release does not fire.
  assign trig = match & ~match_q;

  // The shared timer counts down remaining seconds: ring time in RINGING,
  // snooze time in SNOOZE. A tick seen with timer == 1 is the final second.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    case (state_q)
      IDLE: begin
        timer_d  = 16'd0;
        cnt_d    = 2'd0;
        buzzer_d = 1'b0;
        if (trig) begin
          state_d  = RINGING;
          timer_d  = RING_TICKS;
          buzzer_d = 1'b1;
        end
      end
      RINGING: begin
        if (stop || (sec_tick && timer_q <= 16'd1)) begin
          state_d  = IDLE;
          timer_d  = 16'd0;
          cnt_d    = 2'd0;
          buzzer_d = 1'b0;
        end else if (snooze && (cnt_q < MAX_SN)) begin
          state_d  = SNOOZE;
          timer_d  = SNOOZE_TICKS;
          cnt_d    = cnt_q + 2'd1;
          buzzer_d = 1'b0;
        end else if (sec_tick) begin
          timer_d  = timer_q - 16'd1;
          buzzer_d = ~buzzer_q;
        end
      end
      SNOOZE: begin
        buzzer_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
          timer_d = 16'd0;
          cnt_d   = 2'd0;
        end else if (sec_tick) begin
          if (timer_q <= 16'd1) begin
            state_d  = RINGING;
            timer_d  = RING_TICKS;
            buzzer_d = 1'b1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        timer_d  = 16'd0;
        cnt_d    = 2'd0;
        buzzer_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q  <= IDLE;
      timer_q  <= 16'd0;
      cnt_q    <= 2'd0;
      buzzer_q <= 1'b0;
      match_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      buzzer_q <= buzzer_d;
      match_q  <= match;
    end
  end

  assign ringing    = (state_q == RINGING);
  assign snoozing   = (state_q == SNOOZE);
  assign buzzer     = buzzer_q & ringing;
  assign snooze_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger_module.sv
// ============================================================================
//  Module   : tb_alarm_trigger_module
//  Purpose  : Self-checking bench for alarm_trigger_module. Directed scenarios
//             followed by randomized stimulus, compared every cycle against a
//             behavioural model that counts elapsed seconds.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger_module;

  localparam int RING_S   = 60;
  localparam int SNOOZE_S = 5 * 60;
  localparam int MAX_SN   = 3;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic [12:0] q [7];
  logic [2:0]  day = 3'd0;
  logic [4:0]  hour = 5'd0;
  logic [5:0]  minute = 6'd0;
  logic        sec_tick = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic        buzzer, ringing, snoozing;
  logic [1:0]  snooze_cnt;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = idle, 1 = ringing, 2 = snoozing.
  int m_mode = 0;
  int m_ring_elapsed = 0;
  int m_snz_elapsed = 0;
  int m_cnt = 0;
  bit m_buz = 0;
  bit m_prev = 1;

  always #5 Clk = ~Clk;

  alarm_trigger_module dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .Q_r0       (q[0]),
    .Q_r1       (q[1]),
    .Q_r2       (q[2]),
    .Q_r3       (q[3]),
    .Q_r4       (q[4]),
    .Q_r5       (q[5]),
    .Q_r6       (q[6]),
    .day        (day),
    .hour       (hour),
    .minute     (minute),
    .sec_tick   (sec_tick),
    .snooze     (snooze),
    .stop       (stop),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_match();
    logic [12:0] w;
    if (day == 3'd7) return 0;
    w = q[day];
    return w[0] && (int'(w[12:8]) == int'(hour)) && (int'(w[7:2]) == int'(minute));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ring_elapsed = 0; m_snz_elapsed = 0;
    m_cnt = 0; m_buz = 0; m_prev = 1;
  endtask

  task automatic model_edge();
    bit m, trig;
    m = model_match();
    trig = m && !m_prev;
    m_prev = m;
    case (m_mode)
      0: if (trig) begin m_mode = 1; m_ring_elapsed = 0; m_buz = 1; end
      1: begin
        if (stop || (sec_tick && m_ring_elapsed + 1 == RING_S)) begin
          m_mode = 0; m_cnt = 0; m_buz = 0;
        end else if (snooze && m_cnt < MAX_SN) begin
          m_mode = 2; m_cnt++; m_snz_elapsed = 0; m_buz = 0;
        end else if (sec_tick) begin
          m_ring_elapsed++; m_buz = !m_buz;
        end
      end
      default: begin
        if (stop) begin
          m_mode = 0; m_cnt = 0; m_buz = 0;
        end else if (sec_tick) begin
          m_snz_elapsed++;
          if (m_snz_elapsed == SNOOZE_S) begin
            m_mode = 1; m_ring_elapsed = 0; m_buz = 1;
          end
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ringing"},  {1'b0, ringing},  {1'b0, m_mode == 1});
    check({tag, ".snoozing"}, {1'b0, snoozing}, {1'b0, m_mode == 2});
    check({tag, ".buzzer"},   {1'b0, buzzer},   {1'b0, m_buz});
    check({tag, ".cnt"},      snooze_cnt,       2'(m_cnt));
  endtask

  // One clock: model advances on the edge with the inputs it samples,
  // outputs are compared 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge Clk);
    if (Clr) model_edge(); else model_reset();
    #1;
    check_model(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1; cycle(tag);
      sec_tick = 1'b0; cycle(tag);
    end
  endtask

  task automatic pulse_snooze(input string tag);
    snooze = 1'b1; cycle(tag); snooze = 1'b0;
  endtask

  task automatic set_time(input int h, input int mn);
    hour = 5'(h); minute = 6'(mn);
  endtask

  task automatic fire_0730(input string tag);
    set_time(7, 29); cycle(tag);
    set_time(7, 30); cycle(tag);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) q[i] = 13'd0;

    // Reset state
    cycle("reset"); cycle("reset");
    check("reset.ringing", {1'b0, ringing}, 2'd0);
    check("reset.buzzer",  {1'b0, buzzer},  2'd0);
    check("reset.cnt",     snooze_cnt,      2'd0);
    Clr = 1'b1;

    // Tuesday 07:30 alarm rings one cycle after the match, then times out
    q[2] = {5'd7, 6'd30, 1'b0, 1'b1};
    day = 3'd2;
    fire_0730("trig");
    check("trig.ringing", {1'b0, ringing}, 2'd1);
    check("trig.buzzer",  {1'b0, buzzer},  2'd1);
    sec_tick = 1'b1; cycle("tog"); sec_tick = 1'b0;
    check("toggle.buzzer", {1'b0, buzzer}, 2'd0);
    ticks(RING_S - 2, "ring");
    check("pre_timeout.ringing", {1'b0, ringing}, 2'd1);
    ticks(1, "timeout");
    check("timeout.ringing", {1'b0, ringing}, 2'd0);
    repeat (5) cycle("hold");

    // Wrong day and disabled alarm never ring
    day = 3'd3; fire_0730("wrongday"); ticks(5, "wrongday");
    check("wrongday.ringing", {1'b0, ringing}, 2'd0);
    day = 3'd2; q[2][0] = 1'b0; fire_0730("disabled"); ticks(5, "disabled");
    check("disabled.ringing", {1'b0, ringing}, 2'd0);
    q[2][0] = 1'b1;

    // Snooze up to the limit; the fourth snooze is ignored
    fire_0730("snz");
    for (int k = 1; k <= MAX_SN; k++) begin
      pulse_snooze("snz");
      check("snz.snoozing", {1'b0, snoozing}, 2'd1);
      check("snz.buzzer",   {1'b0, buzzer},   2'd0);
      check("snz.cnt",      snooze_cnt,       2'(k));
      ticks(SNOOZE_S - 1, "snzwait");
      check("snz.notyet", {1'b0, ringing}, 2'd0);
      ticks(1, "snzexp");
      check("snzexp.ringing", {1'b0, ringing}, 2'd1);
    end
    pulse_snooze("snz4");
    check("snz4.ringing", {1'b0, ringing}, 2'd1);
    check("snz4.cnt",     snooze_cnt,      2'd3);

    // Stop and snooze together: stop wins; held minute does not re-fire
    stop = 1'b1; snooze = 1'b1; cycle("stopsnz"); stop = 1'b0; snooze = 1'b0;
    check("stopsnz.ringing", {1'b0, ringing}, 2'd0);
    check("stopsnz.cnt",     snooze_cnt,      2'd0);
    ticks(10, "noretrig");

    // Asynchronous reset during snooze, released while 07:30 still matches
    fire_0730("clr");
    pulse_snooze("clr");
    Clr = 1'b0; #1;
    model_reset();
    check("clr.snoozing", {1'b0, snoozing}, 2'd0);
    check("clr.cnt",      snooze_cnt,      2'd0);
    check_model("clr");
    #1 Clr = 1'b1;
    ticks(5, "clrhold");
    check("clrhold.ringing", {1'b0, ringing}, 2'd0);

    // Invalid day with every word matching
    for (int i = 0; i < 7; i++) q[i] = {5'd7, 6'd30, 1'b0, 1'b1};
    day = 3'd7; fire_0730("day7"); ticks(5, "day7");
    check("day7.ringing", {1'b0, ringing}, 2'd0);

    // Randomized: small time range so matches are frequent
    for (int i = 0; i < 7; i++)
      q[i] = {5'($urandom_range(0, 1)), 6'($urandom_range(0, 1)), 1'($urandom), 1'($urandom_range(0, 3) != 0)};
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) set_time($urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) day = 3'($urandom);
      if ($urandom_range(0, 63) == 0)
        q[$urandom_range(0, 6)] = {5'($urandom_range(0, 1)), 6'($urandom_range(0, 1)), 2'b01};
      sec_tick = ($urandom_range(0, 1) == 0);
      snooze   = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
